// File: rtl/neuron_accum_compare_pkg.sv
// -----------------------------------------------------------------------------
// neuron_accum_compare_pkg
//
// Shared definitions for the multi-beat accumulate-and-compare neuron:
//   - state_t      : two-state controller encoding (accumulating / holding result)
//   - clog2        : ceiling log2, used to size the accumulator and beat counter
//   - ceilDiv      : integer ceiling division, gives the number of beats
//   - accWidth     : accumulator width that cannot overflow for NUM_IN inputs
//   - signExtend   : widens a two's-complement value of arbitrary width to 64 bits
// -----------------------------------------------------------------------------
package neuron_accum_compare_pkg;

    typedef enum logic {
        ST_ACCUM  = 1'b0,
        ST_RESULT = 1'b1
    } state_t;

    // Ceiling log2; clog2(1) is 0 so a single-input neuron adds no growth bits.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    function automatic int ceilDiv(input int numerator, input int denominator);
        return (numerator + denominator - 1) / denominator;
    endfunction

    // Summing numIn values of dataW bits grows the magnitude by at most
    // clog2(numIn) bits, so this width can never overflow.
    function automatic int accWidth(input int dataW, input int numIn);
        return dataW + clog2(numIn);
    endfunction

    // Replicates bit fromW-1 into every position above it.
    function automatic logic [63:0] signExtend(input logic [63:0] value, input int fromW);
        logic [63:0] result;
        result = '0;
        for (int i = 0; i < 64; i++) begin
            result[i] = (i < fromW) ? value[i] : value[fromW-1];
        end
        return result;
    endfunction

endpackage

// File: rtl/neuron_accum_compare_lane_adder_tree.sv
// -----------------------------------------------------------------------------
// lane_adder_tree
//
// Combinational signed sum of LANES two's-complement inputs. Lanes whose mask
// bit is clear contribute zero, which lets the parent ignore padding lanes on
// the final beat when NUM_IN is not a multiple of LANES.
//
// Ports:
//   i_data  in  LANES*DATA_W  lane k at bits [k*DATA_W +: DATA_W], signed
//   i_mask  in  LANES         1 = lane participates in the sum
//   o_sum   out ACC_W         signed sum of enabled lanes
// -----------------------------------------------------------------------------
module lane_adder_tree #(
    parameter int DATA_W = 12,
    parameter int LANES  = 3,
    parameter int ACC_W  = 16
) (
    input  logic [LANES*DATA_W-1:0] i_data,
    input  logic [LANES-1:0]        i_mask,
    output logic [ACC_W-1:0]        o_sum
);

    // Each lane is sign-extended to the full accumulator width before it is
    // added, so negative activations keep their value in the wider sum.
    always_comb begin
        o_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            if (i_mask[k]) begin
                o_sum = o_sum + ACC_W'($signed(i_data[k*DATA_W +: DATA_W]));
            end
        end
    end

endmodule

// File: rtl/neuron_accum_compare.sv
// -----------------------------------------------------------------------------
// neuron_accum_compare
//
// Streams NUM_IN signed activations in as LANES-wide beats, accumulates them
// into a non-overflowing sum, and compares that sum against a per-neuron
// signed threshold captured with the first beat. The binary activation and the
// raw sum are then held under an output valid/ready handshake.
//
// Ports:
//   clk        in  1             rising-edge clock
//   rst        in  1             synchronous active-low reset
//   in_valid   in  1             beat available
//   in_ready   out 1             block can accept a beat
//   in_data    in  LANES*DATA_W  lane k at bits [k*DATA_W +: DATA_W], signed
//   bias       in  BIAS_W        signed threshold, taken with the first beat
//   out_valid  out 1             result available
//   out_ready  in  1             consumer accepts the result
//   out_bit    out 1             binary activation
//   out_sum    out ACC_W         signed accumulated sum
// -----------------------------------------------------------------------------
module neuron_accum_compare
    import neuron_accum_compare_pkg::*;
#(
    parameter  int DATA_W = 12,
    parameter  int NUM_IN = 9,
    parameter  int LANES  = 3,
    parameter  int BIAS_W = 13,
    parameter  int INVERT = 0,
    localparam int ACC_W  = accWidth(DATA_W, NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [BIAS_W-1:0]       bias,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_bit,
    output logic [ACC_W-1:0]        out_sum
);

    localparam int BEATS = ceilDiv(NUM_IN, LANES);
    localparam int CNT_W = (BEATS > 1) ? clog2(BEATS) : 1;

    state_t              r_state;
    logic [CNT_W-1:0]    r_beatCount;
    logic [ACC_W-1:0]    r_acc;
    logic [BIAS_W-1:0]   r_bias;
    logic                r_outValid;
    logic                r_outBit;
    logic [ACC_W-1:0]    r_outSum;

    logic [LANES-1:0]    w_laneMask;
    logic [ACC_W-1:0]    w_laneSum;
    logic [ACC_W-1:0]    w_accNext;
    logic [BIAS_W-1:0]   w_biasEff;
    logic [63:0]         w_accWide;
    logic [63:0]         w_biasWide;
    logic                w_sumGeBias;
    logic                w_cmpBit;
    logic                w_accept;
    logic                w_firstBeat;
    logic                w_lastBeat;

    assign in_ready    = (r_state == ST_ACCUM);
    assign w_accept    = in_valid && in_ready;
    assign w_firstBeat = (r_beatCount == '0);
    assign w_lastBeat  = (r_beatCount == CNT_W'(BEATS - 1));

    // A lane only counts if its position in the overall input vector exists;
    // on the final beat the trailing lanes past NUM_IN are padding.
    always_comb begin
        w_laneMask = '0;
        for (int k = 0; k < LANES; k++) begin
            w_laneMask[k] = ((int'(r_beatCount) * LANES + k) < NUM_IN);
        end
    end

    lane_adder_tree #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .ACC_W  (ACC_W)
    ) u_laneAdderTree (
        .i_data (in_data),
        .i_mask (w_laneMask),
        .o_sum  (w_laneSum)
    );

    // The first beat starts a fresh sum rather than adding to the old one,
    // and the threshold comes straight from the port on that beat because the
    // stored copy has not been written yet (matters when BEATS is 1).
    always_comb begin
        w_accNext = w_firstBeat ? w_laneSum : (r_acc + w_laneSum);
        w_biasEff = w_firstBeat ? bias : r_bias;
    end

    // Both operands are sign-extended to a width well beyond either of them,
    // so the signed compare is exact regardless of which operand is wider.
    // A tie counts as "sum >= bias", so it fires unless the polarity is inverted.
    always_comb begin
        w_accWide   = signExtend(64'(w_accNext), ACC_W);
        w_biasWide  = signExtend(64'(w_biasEff), BIAS_W);
        w_sumGeBias = ($signed(w_accWide) >= $signed(w_biasWide));
        w_cmpBit    = (INVERT != 0) ? !w_sumGeBias : w_sumGeBias;
    end

    // Controller, accumulator and result registers. The result is captured on
    // the same edge that accepts the last beat, so out_valid rises one cycle
    // later and the outputs stay frozen until the consumer takes them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_ACCUM;
            r_beatCount <= '0;
            r_acc       <= '0;
            r_bias      <= '0;
            r_outValid  <= 1'b0;
            r_outBit    <= 1'b0;
            r_outSum    <= '0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_accNext;
                        if (w_firstBeat) begin
                            r_bias <= bias;
                        end
                        if (w_lastBeat) begin
                            r_beatCount <= '0;
                            r_state     <= ST_RESULT;
                            r_outValid  <= 1'b1;
                            r_outSum    <= w_accNext;
                            r_outBit    <= w_cmpBit;
                        end else begin
                            r_beatCount <= r_beatCount + CNT_W'(1);
                        end
                    end
                end
                ST_RESULT: begin
                    if (out_ready) begin
                        r_state    <= ST_ACCUM;
                        r_acc      <= '0;
                        r_outValid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_ACCUM;
                end
            endcase
        end
    end

    assign out_valid = r_outValid;
    assign out_bit   = r_outBit;
    assign out_sum   = r_outSum;

endmodule

// File: tb/tb_neuron_accum_compare.sv
// -----------------------------------------------------------------------------
// tb_neuron_accum_compare
//
// Three instances share the clock: the default build, an INVERT=1 build fed
// the same stream, and a NUM_IN=10 / LANES=4 build with its own stream.
// Expected results are computed from the activation list with plain integer
// arithmetic and queued as each neuron is issued; monitors pop them when the
// corresponding instance hands a result over.
// -----------------------------------------------------------------------------
module tb_neuron_accum_compare;

    typedef struct {
        int sum;
        bit bitv;
    } expect_t;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic [35:0] inData;
    logic [12:0] biasIn;
    logic        outReady;

    logic        inReady;
    logic        outValid;
    logic        outBit;
    logic [15:0] outSum;

    logic        inReadyI;
    logic        outValidI;
    logic        outBitI;
    logic [15:0] outSumI;

    logic        inValidB;
    logic [47:0] inDataB;
    logic [12:0] biasB;
    logic        inReadyB;
    logic        outValidB;
    logic        outBitB;
    logic [15:0] outSumB;

    expect_t qMain[$];
    expect_t qInv[$];
    expect_t qB[$];

    int compared   = 0;
    int mismatched = 0;
    int curVals[12];
    int curBias;
    bit lateBias    = 0;
    bit forceLow    = 0;
    bit randomReady = 0;
    int cycleCount  = 0;
    int lastAcceptCycle = 0;

    neuron_accum_compare #(
        .DATA_W (12), .NUM_IN (9), .LANES (3), .BIAS_W (13), .INVERT (0)
    ) dutMain (
        .clk (clk), .rst (rst),
        .in_valid (inValid), .in_ready (inReady), .in_data (inData), .bias (biasIn),
        .out_valid (outValid), .out_ready (outReady), .out_bit (outBit), .out_sum (outSum)
    );

    neuron_accum_compare #(
        .DATA_W (12), .NUM_IN (9), .LANES (3), .BIAS_W (13), .INVERT (1)
    ) dutInv (
        .clk (clk), .rst (rst),
        .in_valid (inValid), .in_ready (inReadyI), .in_data (inData), .bias (biasIn),
        .out_valid (outValidI), .out_ready (outReady), .out_bit (outBitI), .out_sum (outSumI)
    );

    neuron_accum_compare #(
        .DATA_W (12), .NUM_IN (10), .LANES (4), .BIAS_W (13), .INVERT (0)
    ) dutWide (
        .clk (clk), .rst (rst),
        .in_valid (inValidB), .in_ready (inReadyB), .in_data (inDataB), .bias (biasB),
        .out_valid (outValidB), .out_ready (outReady), .out_bit (outBitB), .out_sum (outSumB)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to measure spacing between completed neurons.
    initial begin
        forever begin
            @(posedge clk);
            cycleCount++;
        end
    end

    // Consumer side: out_ready changes just after the edge, either held high,
    // forced low for a stall, or toggled randomly.
    initial begin
        outReady = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (forceLow)         outReady = 1'b0;
            else if (randomReady) outReady = 1'($urandom_range(0, 1));
            else                  outReady = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: the neuron is just the integer sum of its inputs compared
    // against the threshold; a tie counts as "at or above".
    function automatic expect_t refModel(input int count, input int biasVal, input bit invert);
        expect_t e;
        int s;
        s = 0;
        for (int i = 0; i < count; i++) s += curVals[i];
        e.sum  = s;
        e.bitv = invert ? (s < biasVal) : (s >= biasVal);
        return e;
    endfunction

    // Issues one neuron (curVals[0..8], curBias) to the default and inverted
    // builds. abortBeat >= 0 pulls reset right after that beat is accepted, in
    // which case no result is expected.
    task automatic applyStimulus(input int gap, input int abortBeat);
        int waitCnt;
        if (abortBeat < 0) begin
            qMain.push_back(refModel(9, curBias, 1'b0));
            qInv.push_back(refModel(9, curBias, 1'b1));
        end
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) inData[k*12 +: 12] = 12'(curVals[b*3+k]);
            if (b == 0)        biasIn = 13'(curBias);
            else if (lateBias) biasIn = 13'($urandom_range(0, 8191));
            inValid = 1'b1;
            waitCnt = 0;
            while (!inReady && waitCnt < 100) begin
                @(negedge clk);
                waitCnt++;
            end
            if (!inReady) begin
                checkOutput("in_ready timeout", 0, 1);
                inValid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            inValid = 1'b0;
            if (lateBias) biasIn = 13'($urandom_range(0, 8191));
            if (b == 2) begin
                lastAcceptCycle = cycleCount;
                checkOutput("out_valid latency", int'(outValid), 1);
            end
            if (b == abortBeat) begin
                rst = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    checkOutput("out_valid in reset", int'(outValid), 0);
                end
                rst = 1'b1;
                @(posedge clk);
                #1;
                checkOutput("in_ready after reset", int'(inReady), 1);
                repeat (6) begin
                    @(negedge clk);
                    checkOutput("no output after abort", int'(outValid), 0);
                end
                return;
            end
            if (gap > 0 && b < 2) repeat (gap) @(negedge clk);
        end
    endtask

    // Issues one neuron (curVals[0..11], curBias) to the NUM_IN=10 build;
    // curVals[10..11] sit in padding lanes and must not reach the sum.
    task automatic applyStimulusB(input int gap);
        int waitCnt;
        qB.push_back(refModel(10, curBias, 1'b0));
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) inDataB[k*12 +: 12] = 12'(curVals[b*4+k]);
            if (b == 0) biasB = 13'(curBias);
            inValidB = 1'b1;
            waitCnt  = 0;
            while (!inReadyB && waitCnt < 100) begin
                @(negedge clk);
                waitCnt++;
            end
            if (!inReadyB) begin
                checkOutput("wide in_ready timeout", 0, 1);
                inValidB = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            inValidB = 1'b0;
            if (b == 2) checkOutput("wide out_valid latency", int'(outValidB), 1);
            if (gap > 0 && b < 2) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((qMain.size() + qInv.size() + qB.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("results drained", qMain.size() + qInv.size() + qB.size(), 0);
    endtask

    task automatic fillAll(input int v);
        for (int i = 0; i < 12; i++) curVals[i] = v;
    endtask

    task automatic fillRandom();
        for (int i = 0; i < 12; i++) curVals[i] = int'($urandom_range(0, 4095)) - 2048;
        curBias = int'($urandom_range(0, 8191)) - 4096;
    endtask

    // Monitor for the default and inverted builds: while a result is shown it
    // must match the queue head every cycle (stability under backpressure);
    // it is retired on a handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && outValid) begin
                if (qMain.size() == 0) checkOutput("unexpected out_valid", 1, 0);
                else begin
                    checkOutput("out_sum", int'($signed(outSum)), qMain[0].sum);
                    checkOutput("out_bit", int'(outBit), int'(qMain[0].bitv));
                    checkOutput("in_ready during result", int'(inReady), 0);
                    if (outReady) void'(qMain.pop_front());
                end
            end
            if (rst && outValidI) begin
                if (qInv.size() == 0) checkOutput("unexpected inv out_valid", 1, 0);
                else begin
                    checkOutput("inv out_sum", int'($signed(outSumI)), qInv[0].sum);
                    checkOutput("inv out_bit", int'(outBitI), int'(qInv[0].bitv));
                    if (outReady) void'(qInv.pop_front());
                end
            end
        end
    end

    // Monitor for the NUM_IN=10 / LANES=4 build.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && outValidB) begin
                if (qB.size() == 0) checkOutput("unexpected wide out_valid", 1, 0);
                else begin
                    checkOutput("wide out_sum", int'($signed(outSumB)), qB[0].sum);
                    checkOutput("wide out_bit", int'(outBitB), int'(qB[0].bitv));
                    if (outReady) void'(qB.pop_front());
                end
            end
        end
    end

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        int firstAccept;
        rst      = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        biasIn   = '0;
        inValidB = 1'b0;
        inDataB  = '0;
        biasB    = '0;
        curBias  = 0;
        fillAll(0);

        repeat (3) @(negedge clk);
        checkOutput("reset out_valid", int'(outValid), 0);
        checkOutput("reset out_bit", int'(outBit), 0);
        checkOutput("reset out_sum", int'(outSum), 0);
        checkOutput("reset wide out_valid", int'(outValidB), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("in_ready after reset", int'(inReady), 1);

        $display("[TB] all 512, bias 1024");
        fillAll(512); curBias = 1024;
        applyStimulus(0, -1);
        waitDrain();

        $display("[TB] back-to-back 410 then 153, bias 1484");
        fillAll(410); curBias = 1484;
        applyStimulus(0, -1);
        firstAccept = lastAcceptCycle;
        fillAll(153);
        applyStimulus(0, -1);
        checkOutput("throughput cycles", lastAcceptCycle - firstAccept, 4);
        waitDrain();

        $display("[TB] tie at 1484");
        fillAll(0); curVals[0] = 1484; curBias = 1484;
        applyStimulus(0, -1);
        waitDrain();

        $display("[TB] negative inputs");
        fillAll(-1); curBias = 0;
        applyStimulus(0, -1);
        curBias = -10;
        applyStimulus(0, -1);
        waitDrain();

        $display("[TB] idle gaps between beats");
        fillRandom();
        applyStimulus(2, -1);
        waitDrain();

        $display("[TB] out_ready stall");
        fillRandom();
        forceLow = 1'b1;
        applyStimulus(0, -1);
        repeat (4) begin
            @(negedge clk);
            checkOutput("out_valid held", int'(outValid), 1);
            checkOutput("in_ready held low", int'(inReady), 0);
        end
        forceLow = 1'b0;
        waitDrain();

        $display("[TB] bias changes after beat 0");
        fillRandom();
        lateBias = 1'b1;
        applyStimulus(0, -1);
        lateBias = 1'b0;
        waitDrain();

        $display("[TB] reset mid-neuron");
        fillAll(2047); curBias = 0;
        applyStimulus(0, 1);
        fillAll(7); curBias = 63;
        applyStimulus(0, -1);
        waitDrain();

        $display("[TB] randomized neurons");
        randomReady = 1'b1;
        lateBias    = 1'b1;
        for (int n = 0; n < 40; n++) begin
            fillRandom();
            applyStimulus(int'($urandom_range(0, 2)), -1);
        end
        waitDrain();
        lateBias = 1'b0;

        $display("[TB] NUM_IN=10 LANES=4 build");
        fillAll(1); curVals[10] = 2047; curVals[11] = 2047; curBias = 0;
        applyStimulusB(0);
        curBias = 11;
        applyStimulusB(1);
        for (int n = 0; n < 10; n++) begin
            fillRandom();
            applyStimulusB(int'($urandom_range(0, 2)));
        end
        waitDrain();
        randomReady = 1'b0;

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
